// File: rtl/reg_operand_fetch.sv
// Operand fetch stage for the 8x16 register bank: busy scoreboard, hazard stall,
// same-cycle write forwarding and a valid/ready handoff to execute.
module reg_operand_fetch #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_rs1,
    input  logic [2:0]             req_rs2,
    input  logic [2:0]             req_rd,
    input  logic                   req_wb,
    input  logic [NREG*DATA_W-1:0] reg_bus,
    input  logic                   wr_en,
    input  logic [2:0]             wr_rd,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   op_valid,
    input  logic                   op_ready,
    output logic [DATA_W-1:0]      op_a,
    output logic [DATA_W-1:0]      op_b,
    output logic [2:0]             op_rd,
    output logic                   op_wb,
    output logic [NREG-1:0]        busy,
    output logic [CNT_W-1:0]       stall_cnt
);

    typedef enum logic [1:0] {IDLE, STALL, VALID} state_t;

    state_t            state, next_state;
    logic [2:0]        lat_rs1, lat_rs2, lat_rd;
    logic              lat_wb;
    logic [2:0]        cur_rs1, cur_rs2, cur_rd;
    logic              cur_wb;
    logic              fwd1, fwd2, hazard, capture;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [NREG-1:0]   busy_nxt;

    // While stalled the request comes from the latched copy; otherwise straight from decode.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        cur_rs1 = req_rs1;
        cur_rs2 = req_rs2;
        cur_rd  = req_rd;
        cur_wb  = req_wb;
        if (state == STALL) begin
            cur_rs1 = lat_rs1;
            cur_rs2 = lat_rs2;
            cur_rd  = lat_rd;
            cur_wb  = lat_wb;
        end
    end

    // A write landing this cycle both resolves the hazard and supplies the operand.
    assign fwd1    = wr_en && (wr_rd == cur_rs1);
    assign fwd2    = wr_en && (wr_rd == cur_rs2);
    assign hazard  = (busy[cur_rs1] && !fwd1) || (busy[cur_rs2] && !fwd2);
    assign sel_a   = fwd1 ? wr_data : reg_bus[DATA_W*int'(cur_rs1) +: DATA_W];
    assign sel_b   = fwd2 ? wr_data : reg_bus[DATA_W*int'(cur_rs2) +: DATA_W];
    assign capture = !hazard && ((state == IDLE && req_valid) || state == STALL);

    // Clear first, then set, so a capture to the register being written keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_en)
            busy_nxt[wr_rd] = 1'b0;
        if (capture && cur_wb)
            busy_nxt[cur_rd] = 1'b1;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (req_valid) next_state = hazard ? STALL : VALID;
            STALL:   if (!hazard)   next_state = VALID;
            VALID:   if (op_ready)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = rst_n && (state == IDLE);
        op_valid  = (state == VALID);
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= '0;
            stall_cnt <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_rd     <= '0;
            op_wb     <= 1'b0;
            lat_rs1   <= '0;
            lat_rs2   <= '0;
            lat_rd    <= '0;
            lat_wb    <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= busy_nxt;
            if (state == STALL && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (state == IDLE && req_valid) begin
                lat_rs1 <= req_rs1;
                lat_rs2 <= req_rs2;
                lat_rd  <= req_rd;
                lat_wb  <= req_wb;
            end
            if (capture) begin
                op_a  <= sel_a;
                op_b  <= sel_b;
                op_rd <= cur_rd;
                op_wb <= cur_wb;
            end
        end
    end

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Scoreboard bench for reg_operand_fetch: stimulus pushes expected operands,
// a negedge monitor pops and compares on every op_valid/op_ready handshake.
module tb_reg_operand_fetch;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  rd;
        logic        wb;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_wb, wr_en, op_ready;
    logic [2:0]   req_rs1, req_rs2, req_rd, wr_rd;
    logic [15:0]  wr_data;
    logic [127:0] reg_bus;
    logic [15:0]  regs [8];

    logic         req_ready, op_valid, op_wb;
    logic [15:0]  op_a, op_b;
    logic [2:0]   op_rd;
    logic [7:0]   busy;
    logic [15:0]  stall_cnt;

    // Narrow-counter copy used only to observe saturation.
    logic         s_req_ready, s_op_valid, s_op_wb;
    logic [15:0]  s_op_a, s_op_b;
    logic [2:0]   s_op_rd;
    logic [7:0]   s_busy;
    logic [1:0]   s_stall_cnt;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    always_comb
        for (int i = 0; i < 8; i++)
            reg_bus[16*i +: 16] = regs[i];

    reg_operand_fetch dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_wb(req_wb),
        .reg_bus(reg_bus), .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .op_rd(op_rd), .op_wb(op_wb), .busy(busy), .stall_cnt(stall_cnt)
    );

    reg_operand_fetch #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_wb(req_wb),
        .reg_bus(reg_bus), .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
        .op_valid(s_op_valid), .op_ready(op_ready), .op_a(s_op_a), .op_b(s_op_b),
        .op_rd(s_op_rd), .op_wb(s_op_wb), .busy(s_busy), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current cycle; the caller advances the clock.
    task automatic drive_req(input logic [2:0] rs1, input logic [2:0] rs2,
                             input logic [2:0] rd, input logic wb);
        int waited = 0;
        while (!req_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (waited == 20)
            check("req_ready_timeout", req_ready, 1);
        req_valid = 1'b1;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_rd    = rd;
        req_wb    = wb;
    endtask

    task automatic expect_op(input logic [15:0] a, input logic [15:0] b,
                             input logic [2:0] rd, input logic wb);
        exp_t e;
        e.a = a; e.b = b; e.rd = rd; e.wb = wb;
        exp_q.push_back(e);
    endtask

    // Issue, capture, and let execute consume it (op_ready assumed high).
    task automatic send(input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [2:0] rd, input logic wb,
                        input logic [15:0] a, input logic [15:0] b);
        drive_req(rs1, rs2, rd, wb);
        expect_op(a, b, rd, wb);
        tick();
        req_valid = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        if (rst_n && op_valid && op_ready) begin
            check("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_op_a", op_a, e.a);
                check("mon_op_b", op_b, e.b);
                check("mon_op_rd", op_rd, e.rd);
                check("mon_op_wb", op_wb, e.wb);
            end
        end
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wb = 1'b0; wr_en = 1'b0; op_ready = 1'b1;
        req_rs1 = '0; req_rs2 = '0; req_rd = '0; wr_rd = '0; wr_data = '0;
        regs = '{16'h0A00, 16'h0A11, 16'h0A22, 16'h1234, 16'h0A44, 16'h00FF, 16'h0A66, 16'h0A77};
        tick();
        check("rst_req_ready", req_ready, 0);
        tick();
        check("rst_op_valid", op_valid, 0);
        check("rst_busy", busy, 8'h00);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_op_a", op_a, 0);
        rst_n = 1'b1;
        #1;
        check("idle_req_ready", req_ready, 1);

        // Basic read, one-cycle latency.
        drive_req(3, 5, 0, 0);
        expect_op(16'h1234, 16'h00FF, 0, 0);
        tick();
        req_valid = 1'b0;
        check("t1_op_valid", op_valid, 1);
        check("t1_req_ready", req_ready, 0);
        check("t1_busy", busy, 8'h00);
        check("t1_stall_cnt", stall_cnt, 0);
        tick();
        check("t1_op_valid_drop", op_valid, 0);

        // Write-back to R4 marks it busy; a reader of R4 stalls three cycles.
        send(2, 2, 4, 1, 16'h0A22, 16'h0A22);
        check("t2_busy_set", busy, 8'h10);
        drive_req(4, 0, 7, 0);
        expect_op(16'hBEEF, 16'h0A00, 7, 0);
        tick();
        req_valid = 1'b0;
        check("t2_stall_ready", req_ready, 0);
        check("t2_stall_valid", op_valid, 0);
        tick();
        tick();
        wr_en = 1'b1; wr_rd = 4; wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        regs[4] = 16'hBEEF;
        check("t2_op_valid", op_valid, 1);
        check("t2_busy_clr", busy, 8'h00);
        check("t2_stall_cnt", stall_cnt, 3);
        tick();

        // Same-cycle forwarding of R6 clears the hazard without stalling.
        send(0, 0, 6, 1, 16'h0A00, 16'h0A00);
        check("t3_busy6", busy, 8'h40);
        drive_req(1, 6, 0, 0);
        wr_en = 1'b1; wr_rd = 6; wr_data = 16'hA5A5;
        expect_op(16'h0A11, 16'hA5A5, 0, 0);
        tick();
        req_valid = 1'b0; wr_en = 1'b0;
        regs[6] = 16'hA5A5;
        check("t3_no_stall", op_valid, 1);
        check("t3_stall_cnt", stall_cnt, 3);
        check("t3_busy", busy, 8'h00);
        tick();

        // Backpressure: operands hold while execute is not ready.
        op_ready = 1'b0;
        drive_req(7, 1, 2, 0);
        expect_op(16'h0A77, 16'h0A11, 2, 0);
        tick();
        req_valid = 1'b0;
        regs[7] = 16'h7777;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", op_valid, 1);
            check("t4_hold_a", op_a, 16'h0A77);
            check("t4_hold_b", op_b, 16'h0A11);
            check("t4_hold_ready", req_ready, 0);
            tick();
        end
        op_ready = 1'b1;
        tick();
        check("t4_valid_drop", op_valid, 0);
        check("t4_ready_back", req_ready, 1);

        // Capture to R1 in the same cycle as a write to R1: set wins.
        drive_req(0, 3, 1, 1);
        wr_en = 1'b1; wr_rd = 1; wr_data = 16'h1111;
        expect_op(16'h0A00, 16'h1234, 1, 1);
        tick();
        req_valid = 1'b0; wr_en = 1'b0;
        regs[1] = 16'h1111;
        check("t5_set_wins", busy, 8'h02);
        tick();
        wr_en = 1'b1; wr_rd = 1; wr_data = 16'h2222;
        tick();
        wr_en = 1'b0;
        regs[1] = 16'h2222;
        check("t5_cleared", busy, 8'h00);

        // Fill the scoreboard, stall to a count of 7, then reset mid-stall.
        for (int i = 0; i < 8; i++)
            send(7, 7, 3'(i), 1, 16'h7777, 16'h7777);
        check("t6_busy_full", busy, 8'hFF);
        drive_req(0, 1, 2, 0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++)
            tick();
        check("t6_stall_cnt7", stall_cnt, 7);
        check("t6_sat_cnt", s_stall_cnt, 2'b11);
        check("t6_stall_ready", req_ready, 0);
        rst_n = 1'b0;
        tick();
        check("t6_rst_busy", busy, 8'h00);
        check("t6_rst_cnt", stall_cnt, 0);
        check("t6_rst_valid", op_valid, 0);
        check("t6_rst_rd", op_rd, 0);
        check("t6_rst_ready", req_ready, 0);
        rst_n = 1'b1;
        #1;
        check("t6_idle_ready", req_ready, 1);
        tick();
        check("t6_no_spurious", op_valid, 0);

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
